alu_vector_sequencer: RTL

- Multi-cycle controller that streams one packed vector operation through the single shared scalar `alu` (opcodes 000 add, 001 sub, 010 mul, 011 mod, 101 div), one lane per cycle.
- Sits between vector issue logic and the `alu` instance. It latches both operand vectors, drives the ALU lane by lane, collects per-lane results and reduces the ALU flags into vector-level status.
- Guards div/mod against a zero divisor and rejects reserved opcodes.

---
 rtl/alu_vector_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_vector_sequencer.sv
// Streams one packed vector operation through a shared scalar ALU, one lane per cycle,
// collecting lane results and reducing the ALU flags into vector-level status.
//
// state | meaning
// IDLE  | ready for a new operation; results from the last one are held
// RUN   | driving lane idx into the ALU and capturing its result
// DONE  | one-cycle completion pulse, then back to IDLE
module alu_vector_sequencer #(
    parameter int N     = 32,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         opcode,
    input  logic [N*LANES-1:0] vec_a,
    input  logic [N*LANES-1:0] vec_b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [N*LANES-1:0] vec_result,
    output logic               c_any,
    output logic               o_any,
    output logic               n_any,
    output logic               z_all,
    output logic               err,
    output logic [2:0]         alu_opcode,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    input  logic [N-1:0]       alu_result,
    input  logic               alu_c,
    input  logic               alu_o,
    input  logic               alu_n,
    input  logic               alu_z
);

    localparam int IW = $clog2(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      nxt_idx;
    logic [N*LANES-1:0] op_a;
    logic [N*LANES-1:0] op_b;
    logic               reserved_op;
    logic               div_by_zero;

    // alu_opcode doubles as the latched opcode for the whole operation
    assign reserved_op = (alu_opcode == 3'b100) || (alu_opcode == 3'b110) ||
                         (alu_opcode == 3'b111);
    assign div_by_zero = ((alu_opcode == 3'b011) || (alu_opcode == 3'b101)) &&
                         (alu_b == '0);
    assign nxt_idx     = idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            vec_result <= '0;
            c_any      <= 1'b0;
            o_any      <= 1'b0;
            n_any      <= 1'b0;
            z_all      <= 1'b0;
            err        <= 1'b0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            alu_opcode <= 3'b000;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a       <= vec_a;
                        op_b       <= vec_b;
                        alu_opcode <= opcode;
                        alu_a      <= vec_a[N-1:0];
                        alu_b      <= vec_b[N-1:0];
                        vec_result <= '0;
                        c_any      <= 1'b0;
                        o_any      <= 1'b0;
                        n_any      <= 1'b0;
                        z_all      <= 1'b1;
                        err        <= 1'b0;
                        idx        <= '0;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Guarded lanes read as zero and keep the ALU flags out of the reduction
                    if (reserved_op || div_by_zero) begin
                        vec_result[idx*N +: N] <= '0;
                        err                    <= 1'b1;
                    end else begin
                        vec_result[idx*N +: N] <= alu_result;
                        c_any                  <= c_any | alu_c;
                        o_any                  <= o_any | alu_o;
                        n_any                  <= n_any | alu_n;
                        z_all                  <= z_all & alu_z;
                    end
                    if (idx == LAST) begin
                        idx   <= '0;
                        alu_a <= '0;
                        alu_b <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= nxt_idx;
                        alu_a <= op_a[nxt_idx*N +: N];
                        alu_b <= op_b[nxt_idx*N +: N];
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
